// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter that shares one single-port 16 x 16-bit RAM
// between an instruction-fetch port (A) and a data load/store port (B).
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request; held stable until a_ack
//   a_ack                       port A access performed this cycle
//   a_rdata/a_rvalid            port A captured read data + one-cycle valid
//   b_*                         same set for port B
//   ram_wr_en/ram_rd_en         RAM strobes (only master of these pins)
//   ram_addr/ram_data_in        RAM address and write data
//   ram_data_out                RAM read data, combinational from address
//   busy                        arbiter is serving a port this cycle
module ram_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          ram_wr_en,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_e;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          a_rvalid_q, b_rvalid_q;
  logic          ra, rb;

  // Next-state: the port served in the current cycle is masked so its
  // requester has one cycle to drop req after seeing ack.
  always_comb begin
    ra      = a_req & (state_q != SERVE_A);
    rb      = b_req & (state_q != SERVE_B);
    state_d = IDLE;
    last_d  = last_q;
    if (ra && rb)  state_d = (last_q == LAST_B) ? SERVE_A : SERVE_B;
    else if (ra)   state_d = SERVE_A;
    else if (rb)   state_d = SERVE_B;
    if (state_d == SERVE_A) last_d = LAST_A;
    if (state_d == SERVE_B) last_d = LAST_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= LAST_B;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      // Capture at the edge that closes a read slot; rdata holds otherwise.
      a_rvalid_q <= (state_q == SERVE_A) & ~a_we;
      b_rvalid_q <= (state_q == SERVE_B) & ~b_we;
      if ((state_q == SERVE_A) && !a_we) a_rdata_q <= ram_data_out;
      if ((state_q == SERVE_B) && !b_we) b_rdata_q <= ram_data_out;
    end
  end

  // RAM pin mux. Strobes and acks are gated by rst so a reset landing in the
  // middle of a serve slot can never commit a write.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    unique case (state_q)
      SERVE_A: begin
        ram_addr    = a_addr;
        ram_data_in = a_wdata;
        ram_wr_en   = a_we & ~rst;
        ram_rd_en   = ~a_we & ~rst;
        a_ack       = ~rst;
      end
      SERVE_B: begin
        ram_addr    = b_addr;
        ram_data_in = b_wdata;
        ram_wr_en   = b_we & ~rst;
        ram_rd_en   = ~b_we & ~rst;
        b_ack       = ~rst;
      end
      default: ;
    endcase
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  logic        clk, rst;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_wr_en, ram_rd_en;
  logic [3:0]  ram_addr;
  logic [15:0] ram_data_in, ram_data_out;
  logic        busy;

  ram_arbiter #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: combinational read, write on rising edge.
  logic [15:0] tb_ram [16];
  assign ram_data_out = tb_ram[ram_addr];
  always @(posedge clk) if (ram_wr_en) tb_ram[ram_addr] <= ram_data_in;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit mon_en = 0;
  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: which port owns each slot, with a reference memory.
  // served: 0 = nobody, 1 = A, 2 = B. A port owning a slot cannot own the next;
  // a tie goes to whichever port did not own the most recent slot.
  int          served = 0;
  bit          last_was_b = 1;
  logic [15:0] ref_mem [16];
  logic [15:0] qa[$], qb[$];
  bit          exp_arv = 0, exp_brv = 0;

  always @(posedge clk) begin
    int nxt;
    bit wa, wb;
    exp_arv = 0;
    exp_brv = 0;
    if (rst) begin
      served     = 0;
      last_was_b = 1;
    end else begin
      if (served == 1) begin
        if (a_we) ref_mem[a_addr] = a_wdata;
        else begin qa.push_back(ref_mem[a_addr]); exp_arv = 1; end
      end
      if (served == 2) begin
        if (b_we) ref_mem[b_addr] = b_wdata;
        else begin qb.push_back(ref_mem[b_addr]); exp_brv = 1; end
      end
      wa = a_req && (served != 1);
      wb = b_req && (served != 2);
      if (wa && wb)  nxt = last_was_b ? 1 : 2;
      else if (wa)   nxt = 1;
      else if (wb)   nxt = 2;
      else           nxt = 0;
      if (nxt == 1) last_was_b = 0;
      if (nxt == 2) last_was_b = 1;
      served = nxt;
    end
  end

  // Monitor: compares DUT outputs against the model every cycle; read data is
  // popped from the scoreboard queues when a read completion is due.
  always @(negedge clk) begin
    logic [3:0]  e_addr;
    logic [15:0] e_din;
    bit          e_we;
    if (mon_en) begin
      e_addr = (served == 1) ? a_addr  : (served == 2) ? b_addr  : 4'd0;
      e_din  = (served == 1) ? a_wdata : (served == 2) ? b_wdata : 16'd0;
      e_we   = (served == 1) ? a_we    : b_we;
      chk("a_ack", a_ack, (served == 1) && !rst);
      chk("b_ack", b_ack, (served == 2) && !rst);
      chk("busy", busy, served != 0);
      chk("ram_wr_en", ram_wr_en, (served != 0) && e_we && !rst);
      chk("ram_rd_en", ram_rd_en, (served != 0) && !e_we && !rst);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_data_in", ram_data_in, e_din);
      chk("a_rvalid", a_rvalid, exp_arv);
      chk("b_rvalid", b_rvalid, exp_brv);
      if (exp_arv) begin
        if (qa.size() == 0) begin checks++; errors++; $display("FAIL a_scoreboard empty"); end
        else chk("a_rdata", a_rdata, qa.pop_front());
      end
      if (exp_brv) begin
        if (qb.size() == 0) begin checks++; errors++; $display("FAIL b_scoreboard empty"); end
        else chk("b_rdata", b_rdata, qb.pop_front());
      end
    end
  end

  // One access on port p (0 = A, 1 = B). Returns the cycle of its ack.
  task automatic access(input bit p, input bit we, input logic [3:0] addr,
                        input logic [15:0] wd, output int cyc);
    if (!p) begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1; end
    else    begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1; end
    cyc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (p ? b_ack : a_ack) begin cyc = cycle; break; end
    end
    if (cyc < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout port=%0d got no ack expected ack within 64 cycles", p);
    end
    @(posedge clk); #1;
    if (!p) a_req = 0; else b_req = 0;
  endtask

  task automatic do_reset();
    rst = 1; a_req = 0; b_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic tie_reads();
    int ca, cb;
    fork
      access(0, 0, 4'd0, 16'd0, ca);
      access(1, 0, 4'd1, 16'd0, cb);
    join
    chk("tie_b_after_a", cb - ca, 1);
    @(negedge clk);
    chk("tie_a_rdata", a_rdata, 16'd770);
    chk("tie_b_rdata", b_rdata, 16'd1029);
  endtask

  initial begin
    int c0, c1;
    bit prev_a, prev_b;
    rst = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    for (int i = 0; i < 16; i++) begin tb_ram[i] = 16'd0; ref_mem[i] = 16'd0; end
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_a_ack", a_ack, 0);       chk("rst_b_ack", b_ack, 0);
    chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
    chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", ram_wr_en, 0);   chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_addr", ram_addr, 0);     chk("rst_din", ram_data_in, 0);
    mon_en = 1;
    @(posedge clk); #1;

    // Port A write then read addr 5
    access(0, 1, 4'd5, 16'h1234, c0);
    @(posedge clk); #1;
    access(0, 0, 4'd5, 16'h0000, c0);
    @(negedge clk);
    chk("a_read_rvalid", a_rvalid, 1);
    chk("a_read_rdata", a_rdata, 16'h1234);

    // Preload, then tie from reset
    access(0, 1, 4'd0, 16'd770, c0);
    access(1, 1, 4'd1, 16'd1029, c0);
    access(0, 1, 4'd3, 16'h1111, c0);
    do_reset();
    tie_reads();

    // Continuous back-to-back requests on both ports
    fork
      for (int i = 0; i < 8; i++) access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(8, 15)), 16'($urandom), c0);
      for (int i = 0; i < 8; i++) access(1, 1'($urandom_range(0, 1)), 4'($urandom_range(8, 15)), 16'($urandom), c1);
      begin
        for (int i = 0; i < 64 && !(a_ack || b_ack); i++) @(negedge clk);
        prev_a = 0; prev_b = 0;
        for (int i = 0; i < 12; i++) begin
          chk("cont_strobe", ram_rd_en | ram_wr_en, 1);
          chk("cont_one_ack", a_ack ^ b_ack, 1);
          chk("cont_a_consec", a_ack & prev_a, 0);
          chk("cont_b_consec", b_ack & prev_b, 0);
          prev_a = a_ack; prev_b = b_ack;
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;

    // Reset in the middle of a port B write to addr 3
    b_we = 1; b_addr = 4'd3; b_wdata = 16'hBEEF; b_req = 1;
    for (int i = 0; i < 64; i++) begin @(negedge clk); if (b_ack) break; end
    #2 rst = 1;
    #1;
    chk("midrst_wr_en", ram_wr_en, 0);
    chk("midrst_b_ack", b_ack, 0);
    @(posedge clk); #1;
    rst = 0; b_req = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr3", tb_ram[3], 16'h1111);
    @(posedge clk); #1;
    tie_reads();

    // Collision: A writes addr 7 while B reads it; A granted first
    fork
      access(0, 1, 4'd7, 16'h00AA, c0);
      access(1, 0, 4'd7, 16'h0000, c1);
    join
    @(negedge clk);
    chk("coll_b_rdata", b_rdata, 16'h00AA);
    @(posedge clk); #1;

    // Randomized traffic on a small address window to force collisions
    fork
      for (int i = 0; i < 40; i++) begin
        int g = $urandom_range(0, 3);
        if (g != 0) begin repeat (g) @(posedge clk); #1; end
        access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom), c0);
      end
      for (int i = 0; i < 40; i++) begin
        int g = $urandom_range(0, 3);
        if (g != 0) begin repeat (g) @(posedge clk); #1; end
        access(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom), c1);
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
